// File: rtl/register_file_32x32_pkg.sv
`default_nettype none
// ============================================================================
// Module   : register_file_32x32_pkg
// Purpose  : Shared register-file constants, also used by the control unit
//            and the pipeline registers.
// Revision : 1.0 - initial release
// ============================================================================
package register_file_32x32_pkg;

    localparam int          REG_DATA_WIDTH  = 32;
    localparam int          REG_ADDR_WIDTH  = 5;
    localparam int          REG_ZERO_INDEX  = 0;
    localparam logic [31:0] REG_RESET_VALUE = 32'h0000_0000;

endpackage : register_file_32x32_pkg
`default_nettype wire

// File: rtl/register_file_32x32_decoder_5to32.sv
`default_nettype none
// ============================================================================
// Module   : register_file_32x32_decoder_5to32
// Purpose  : Turns the write index plus write strobe into a one-hot
//            write-select vector, with the select bit for register 0 held low.
// Revision : 1.0 - initial release
// ============================================================================
module register_file_32x32_decoder_5to32
    import register_file_32x32_pkg::*;
#(
    parameter int ADDR_WIDTH = REG_ADDR_WIDTH
) (
    input  logic [ADDR_WIDTH-1:0]    addr,
    input  logic                     enable,
    output logic [2**ADDR_WIDTH-1:0] select
);

    always_comb begin
        select = '0;
        // Case equality keeps an unknown strobe from selecting anything in simulation
        if (enable === 1'b1) begin
            select[addr] = 1'b1;
        end
        select[REG_ZERO_INDEX] = 1'b0;
    end

endmodule : register_file_32x32_decoder_5to32
`default_nettype wire

// File: rtl/register_file_32x32.sv
`default_nettype none
// ============================================================================
// Module   : register_file_32x32
// Purpose  : 32 x 32-bit register file with two combinational read ports,
//            one clocked write port and register 0 hardwired to zero.
//            Optional macro REGFILE_WRITE_BYPASS_EN adds write-through reads.
// Revision : 1.0 - initial release
// ============================================================================
module register_file_32x32
    import register_file_32x32_pkg::*;
#(
    parameter int DATA_WIDTH = REG_DATA_WIDTH,
    parameter int ADDR_WIDTH = REG_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] readReg1,
    input  logic [ADDR_WIDTH-1:0] readReg2,
    input  logic [ADDR_WIDTH-1:0] writeReg,
    input  logic [DATA_WIDTH-1:0] writeData,
    input  logic                  writeEnable,
    output logic [DATA_WIDTH-1:0] readData1,
    output logic [DATA_WIDTH-1:0] readData2
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] c_zero_idx = ADDR_WIDTH'(REG_ZERO_INDEX);

    logic [DEPTH-1:0]      w_write_sel;
    logic                  w_unused_sel0;
    logic [DATA_WIDTH-1:0] r_regs [1:DEPTH-1];

    register_file_32x32_decoder_5to32 #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_decoder (
        .addr   (writeReg),
        .enable (writeEnable),
        .select (w_write_sel)
    );

    // Register 0 has no storage, so its select bit goes nowhere
    assign w_unused_sel0 = w_write_sel[0];

    generate
        for (genvar i = 1; i < DEPTH; i++) begin : g_regs
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_regs[i] <= DATA_WIDTH'(REG_RESET_VALUE);
                end else if (w_write_sel[i]) begin
                    r_regs[i] <= writeData;
                end
            end
        end
    endgenerate

    always_comb begin
        readData1 = '0;
        readData2 = '0;
        if (readReg1 != c_zero_idx) begin
            readData1 = r_regs[readReg1];
        end
        if (readReg2 != c_zero_idx) begin
            readData2 = r_regs[readReg2];
        end
`ifdef REGFILE_WRITE_BYPASS_EN
        // Write-through lets decode see a value being written back this cycle
        if (!reset && (writeEnable === 1'b1) && (writeReg != c_zero_idx)) begin
            if (writeReg == readReg1) begin
                readData1 = writeData;
            end
            if (writeReg == readReg2) begin
                readData2 = writeData;
            end
        end
`endif
    end

endmodule : register_file_32x32
`default_nettype wire

// File: tb/tb_register_file_32x32.sv
`default_nettype none
// ============================================================================
// Module   : tb_register_file_32x32
// Purpose  : Self-checking bench for register_file_32x32 against an array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_register_file_32x32;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  readReg1, readReg2, writeReg;
    logic [31:0] writeData;
    logic        writeEnable;
    logic [31:0] readData1, readData2;

    logic [31:0] model [32];
    int          n_total = 0;
    int          n_bad   = 0;

    always #5 clk = ~clk;

    register_file_32x32 dut (
        .clk         (clk),
        .reset       (reset),
        .readReg1    (readReg1),
        .readReg2    (readReg2),
        .writeReg    (writeReg),
        .writeData   (writeData),
        .writeEnable (writeEnable),
        .readData1   (readData1),
        .readData2   (readData2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_read(input logic [4:0] idx);
        if (idx == 5'd0 || reset) return 32'h0;
`ifdef REGFILE_WRITE_BYPASS_EN
        if (writeEnable && writeReg == idx) return writeData;
`endif
        return model[idx];
    endfunction

    // One full cycle: drive at negedge, check reads before and after the edge
    task automatic cycle(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                         input logic [4:0] r1, input logic [4:0] r2, input string tag);
        @(negedge clk);
        writeEnable = we; writeReg = wr; writeData = wd;
        readReg1 = r1; readReg2 = r2;
        #1;
        check({tag, "_pre1"}, readData1, exp_read(r1));
        check({tag, "_pre2"}, readData2, exp_read(r2));
        @(posedge clk);
        if (we && !reset && wr != 5'd0) model[wr] = wd;
        #1;
        check({tag, "_post1"}, readData1, exp_read(r1));
        check({tag, "_post2"}, readData2, exp_read(r2));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        reset = 1'b1; writeEnable = 1'b0; writeReg = '0; writeData = '0;
        readReg1 = 5'd1; readReg2 = 5'd31;
        #1;
        check("reset_r1", readData1, 32'h0);
        check("reset_r31", readData2, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Basic write/read plus neighbours untouched
        cycle(1'b1, 5'd7, 32'hDEAD_BEEF, 5'd7, 5'd7, "wr7");
        check("r7_port1", readData1, 32'hDEAD_BEEF);
        check("r7_port2", readData2, 32'hDEAD_BEEF);
        cycle(1'b0, 5'd0, 32'h0, 5'd6, 5'd8, "nbr");
        check("r6_zero", readData1, 32'h0);
        check("r8_zero", readData2, 32'h0);

        // Register 0 ignores writes
        cycle(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, "zero");
        check("r0_stays0", readData1, 32'h0);

        // Write disabled
        cycle(1'b1, 5'd3, 32'h0000_0011, 5'd3, 5'd0, "wr3");
        cycle(1'b0, 5'd3, 32'hA5A5_A5A5, 5'd3, 5'd3, "we0");
        check("r3_kept", readData1, 32'h0000_0011);

        // Read-during-write on port 2
        cycle(1'b1, 5'd9, 32'h1, 5'd0, 5'd9, "wr9a");
        @(negedge clk);
        writeEnable = 1'b1; writeReg = 5'd9; writeData = 32'h2; readReg2 = 5'd9;
        #1;
`ifdef REGFILE_WRITE_BYPASS_EN
        check("rdw_before", readData2, 32'h2);
`else
        check("rdw_before", readData2, 32'h1);
`endif
        @(posedge clk);
        model[9] = 32'h2;
        #1;
        check("rdw_after", readData2, 32'h2);

        // Asynchronous reset clears without a clock edge
        cycle(1'b1, 5'd5, 32'h1234_5678, 5'd5, 5'd5, "wr5");
        @(negedge clk);
        writeEnable = 1'b0; readReg1 = 5'd5;
        #1;
        check("r5_before_rst", readData1, 32'h1234_5678);
        reset = 1'b1;
        #1;
        check("r5_async_rst", readData1, 32'h0);
        for (int i = 0; i < 32; i++) model[i] = 32'h0;

        // Reset overrides a simultaneous write
        writeEnable = 1'b1; writeReg = 5'd4; writeData = 32'hCAFE_0000; readReg2 = 5'd4;
        @(posedge clk);
        #1;
        check("r4_in_rst", readData2, 32'h0);
        @(negedge clk);
        reset = 1'b0; writeEnable = 1'b0;
        #1;
        check("r4_after_rst", readData2, 32'h0);
        check("r9_after_rst", exp_read(5'd9) ^ 32'h0, 32'h0);

        // Randomized traffic, biased so reads often hit the written index
        for (int n = 0; n < 400; n++) begin
            logic [4:0]  wr;
            logic [4:0]  r1;
            logic [4:0]  r2;
            wr = 5'($urandom_range(0, 31));
            r1 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
            r2 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
            cycle(1'($urandom_range(0, 1)), wr, $urandom, r1, r2, "rand");
        end

        // Final sweep of every register
        for (int i = 0; i < 32; i++) begin
            cycle(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), "sweep");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_register_file_32x32
`default_nettype wire
